// File: rtl/quote_egress_sched.sv
// Egress scheduler: one coalescing slot per stock, round-robin service, and each quote
// emitted as a BUY beat then a SELL beat over a valid/ready register bank.
module quote_egress_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int QTY_WIDTH  = 16,
   parameter int NUM_STOCKS = 4,
   parameter int REG_WIDTH  = 32,
   localparam int SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_quote_valid,
   input  logic [SID_W-1:0]      i_stock_id,
   input  logic [DATA_WIDTH-1:0] i_buy_price,
   input  logic [DATA_WIDTH-1:0] i_sell_price,
   input  logic [QTY_WIDTH-1:0]  i_buy_qty,
   input  logic [QTY_WIDTH-1:0]  i_sell_qty,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [REG_WIDTH-1:0]  o_reg_1,
   output logic [REG_WIDTH-1:0]  o_reg_2,
   output logic [REG_WIDTH-1:0]  o_reg_3,
   output logic [REG_WIDTH-1:0]  o_reg_4,
   output logic [NUM_STOCKS-1:0] o_pending,
   output logic [15:0]           o_coalesce_cnt
);

   // Handshake: a beat transfers on any cycle where o_valid && i_ready; while o_valid is
   // high and i_ready is low, every o_reg_* holds its value.

   typedef enum logic [1:0] {ST_IDLE, ST_BUY, ST_SELL} state_t;

   localparam logic [SID_W:0] NUM_S = (SID_W + 1)'(NUM_STOCKS);

   state_t                  state_q, state_d;
   logic [SID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [REG_WIDTH-1:0]    seq_q, seq_d;
   logic [15:0]             coal_q, coal_d;
   logic [NUM_STOCKS-1:0]   pending_q, pending_d;

   logic [DATA_WIDTH-1:0]   slot_bp_q [NUM_STOCKS];
   logic [DATA_WIDTH-1:0]   slot_bp_d [NUM_STOCKS];
   logic [DATA_WIDTH-1:0]   slot_sp_q [NUM_STOCKS];
   logic [DATA_WIDTH-1:0]   slot_sp_d [NUM_STOCKS];
   logic [QTY_WIDTH-1:0]    slot_bq_q [NUM_STOCKS];
   logic [QTY_WIDTH-1:0]    slot_bq_d [NUM_STOCKS];
   logic [QTY_WIDTH-1:0]    slot_sq_q [NUM_STOCKS];
   logic [QTY_WIDTH-1:0]    slot_sq_d [NUM_STOCKS];

   logic [SID_W-1:0]        tx_sid_q, tx_sid_d;
   logic [DATA_WIDTH-1:0]   tx_bp_q, tx_bp_d;
   logic [DATA_WIDTH-1:0]   tx_sp_q, tx_sp_d;
   logic [QTY_WIDTH-1:0]    tx_bq_q, tx_bq_d;
   logic [QTY_WIDTH-1:0]    tx_sq_q, tx_sq_d;

   logic                    valid_q, valid_d;
   logic [REG_WIDTH-1:0]    reg_1_q, reg_1_d;
   logic [REG_WIDTH-1:0]    reg_2_q, reg_2_d;
   logic [REG_WIDTH-1:0]    reg_3_q, reg_3_d;
   logic [REG_WIDTH-1:0]    reg_4_q, reg_4_d;

   logic                    wr_en;
   logic                    latch;
   logic                    accept;
   logic                    pick_found;
   logic [SID_W-1:0]        pick_idx;
   logic [SID_W-1:0]        cand_idx;
   int                      cand;

   // Round-robin search: first pending slot strictly after the pointer, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 1; k <= NUM_STOCKS; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_STOCKS) begin
            cand = cand - NUM_STOCKS;
         end
         cand_idx = SID_W'(cand);
         if (!pick_found && pending_q[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      wr_en  = i_quote_valid && ((i_buy_qty != '0) || (i_sell_qty != '0))
               && ({1'b0, i_stock_id} < NUM_S);
      latch  = (state_q == ST_IDLE) && pick_found;
      accept = valid_q && i_ready;

      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      seq_d     = seq_q;
      coal_d    = coal_q;
      pending_d = pending_q;
      slot_bp_d = slot_bp_q;
      slot_sp_d = slot_sp_q;
      slot_bq_d = slot_bq_q;
      slot_sq_d = slot_sq_q;
      tx_sid_d  = tx_sid_q;
      tx_bp_d   = tx_bp_q;
      tx_sp_d   = tx_sp_q;
      tx_bq_d   = tx_bq_q;
      tx_sq_d   = tx_sq_q;

      case (state_q)
         ST_IDLE: begin
            if (latch) begin
               tx_sid_d = pick_idx;
               tx_bp_d  = slot_bp_q[pick_idx];
               tx_sp_d  = slot_sp_q[pick_idx];
               tx_bq_d  = slot_bq_q[pick_idx];
               tx_sq_d  = slot_sq_q[pick_idx];
               rr_ptr_d = pick_idx;
               state_d  = (slot_bq_q[pick_idx] != '0) ? ST_BUY : ST_SELL;
            end
         end
         ST_BUY: begin
            if (accept) begin
               seq_d   = seq_q + REG_WIDTH'(1);
               state_d = (tx_sq_q != '0) ? ST_SELL : ST_IDLE;
            end
         end
         ST_SELL: begin
            if (accept) begin
               seq_d   = seq_q + REG_WIDTH'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The latch reads old slot data above; a same-cycle write then refills the slot.
      for (int i = 0; i < NUM_STOCKS; i++) begin
         if (latch && (pick_idx == SID_W'(i))) begin
            pending_d[i] = 1'b0;
         end
         if (wr_en && (i_stock_id == SID_W'(i))) begin
            slot_bp_d[i] = i_buy_price;
            slot_sp_d[i] = i_sell_price;
            slot_bq_d[i] = i_buy_qty;
            slot_sq_d[i] = i_sell_qty;
            pending_d[i] = 1'b1;
            if (pending_q[i] && !(latch && (pick_idx == SID_W'(i))) && (coal_q != 16'hFFFF)) begin
               coal_d = coal_q + 16'd1;
            end
         end
      end

      valid_d = (state_d != ST_IDLE);
      reg_1_d = '0;
      reg_2_d = '0;
      reg_3_d = '0;
      reg_4_d = '0;
      if (valid_d) begin
         reg_1_d = REG_WIDTH'({(state_d == ST_SELL), tx_sid_d});
         reg_4_d = seq_d;
         if (state_d == ST_SELL) begin
            reg_2_d = REG_WIDTH'(tx_sp_d);
            reg_3_d = REG_WIDTH'(tx_sq_d);
         end else begin
            reg_2_d = REG_WIDTH'(tx_bp_d);
            reg_3_d = REG_WIDTH'(tx_bq_d);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= SID_W'(NUM_STOCKS - 1);
         seq_q     <= '0;
         coal_q    <= '0;
         pending_q <= '0;
         for (int i = 0; i < NUM_STOCKS; i++) begin
            slot_bp_q[i] <= '0;
            slot_sp_q[i] <= '0;
            slot_bq_q[i] <= '0;
            slot_sq_q[i] <= '0;
         end
         tx_sid_q  <= '0;
         tx_bp_q   <= '0;
         tx_sp_q   <= '0;
         tx_bq_q   <= '0;
         tx_sq_q   <= '0;
         valid_q   <= 1'b0;
         reg_1_q   <= '0;
         reg_2_q   <= '0;
         reg_3_q   <= '0;
         reg_4_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         seq_q     <= seq_d;
         coal_q    <= coal_d;
         pending_q <= pending_d;
         slot_bp_q <= slot_bp_d;
         slot_sp_q <= slot_sp_d;
         slot_bq_q <= slot_bq_d;
         slot_sq_q <= slot_sq_d;
         tx_sid_q  <= tx_sid_d;
         tx_bp_q   <= tx_bp_d;
         tx_sp_q   <= tx_sp_d;
         tx_bq_q   <= tx_bq_d;
         tx_sq_q   <= tx_sq_d;
         valid_q   <= valid_d;
         reg_1_q   <= reg_1_d;
         reg_2_q   <= reg_2_d;
         reg_3_q   <= reg_3_d;
         reg_4_q   <= reg_4_d;
      end
   end

   assign o_valid        = valid_q;
   assign o_reg_1        = reg_1_q;
   assign o_reg_2        = reg_2_q;
   assign o_reg_3        = reg_3_q;
   assign o_reg_4        = reg_4_q;
   assign o_pending      = pending_q;
   assign o_coalesce_cnt = coal_q;

endmodule

// File: tb/tb_quote_egress_sched.sv
// Directed bench for quote_egress_sched: hand-computed beats, coalescing, round-robin order,
// same-slot write/latch race and mid-beat reset.
module tb_quote_egress_sched;

   logic        clk;
   logic        i_reset;
   logic        i_quote_valid;
   logic [1:0]  i_stock_id;
   logic [31:0] i_buy_price;
   logic [31:0] i_sell_price;
   logic [15:0] i_buy_qty;
   logic [15:0] i_sell_qty;
   logic        i_ready;
   logic        o_valid;
   logic [31:0] o_reg_1;
   logic [31:0] o_reg_2;
   logic [31:0] o_reg_3;
   logic [31:0] o_reg_4;
   logic [3:0]  o_pending;
   logic [15:0] o_coalesce_cnt;

   int n_checks = 0;
   int n_errors = 0;

   quote_egress_sched dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_quote_valid  (i_quote_valid),
      .i_stock_id     (i_stock_id),
      .i_buy_price    (i_buy_price),
      .i_sell_price   (i_sell_price),
      .i_buy_qty      (i_buy_qty),
      .i_sell_qty     (i_sell_qty),
      .i_ready        (i_ready),
      .o_valid        (o_valid),
      .o_reg_1        (o_reg_1),
      .o_reg_2        (o_reg_2),
      .o_reg_3        (o_reg_3),
      .o_reg_4        (o_reg_4),
      .o_pending      (o_pending),
      .o_coalesce_cnt (o_coalesce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input string tag, input int sid, input int side,
                             input int price, input int qty, input int seq);
      check({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, ".reg1"}, o_reg_1, 32'(side * 4 + sid));
      check({tag, ".reg2"}, o_reg_2, 32'(price));
      check({tag, ".reg3"}, o_reg_3, 32'(qty));
      check({tag, ".reg4"}, o_reg_4, 32'(seq));
   endtask

   task automatic check_idle(input string tag, input logic [3:0] pend);
      check({tag, ".valid"}, {31'd0, o_valid}, 32'd0);
      check({tag, ".pending"}, {28'd0, o_pending}, {28'd0, pend});
   endtask

   // Present a quote for one cycle; returns in the cycle after it was written.
   task automatic send_quote(input int sid, input int bp, input int sp, input int bq, input int sq);
      i_quote_valid = 1'b1;
      i_stock_id    = 2'(sid);
      i_buy_price   = 32'(bp);
      i_sell_price  = 32'(sp);
      i_buy_qty     = 16'(bq);
      i_sell_qty    = 16'(sq);
      step();
      i_quote_valid = 1'b0;
   endtask

   initial begin
      i_reset       = 1'b1;
      i_quote_valid = 1'b0;
      i_stock_id    = '0;
      i_buy_price   = '0;
      i_sell_price  = '0;
      i_buy_qty     = '0;
      i_sell_qty    = '0;
      i_ready       = 1'b0;
      step();
      step();
      i_reset = 1'b0;
      step();

      // Reset state
      check_idle("rst", 4'b0000);
      check("rst.reg1", o_reg_1, 32'd0);
      check("rst.reg4", o_reg_4, 32'd0);
      check("rst.coal", {16'd0, o_coalesce_cnt}, 32'd0);

      // 1: basic two-beat quote, two-cycle latency
      i_ready = 1'b1;
      send_quote(1, 100, 102, 10, 5);
      check_idle("t1.n1", 4'b0010);
      step();
      check_beat("t1.buy", 1, 0, 100, 10, 0);
      check("t1.buy.pending", {28'd0, o_pending}, 32'd0);
      step();
      check_beat("t1.sell", 1, 1, 102, 5, 1);
      step();
      check_idle("t1.end", 4'b0000);

      // 2: back-pressure holds the BUY beat stable
      i_ready = 1'b0;
      send_quote(2, 200, 201, 20, 21);
      check_idle("t2.n1", 4'b0100);
      step();
      check_beat("t2.buy", 2, 0, 200, 20, 2);
      for (int c = 0; c < 5; c++) begin
         step();
         check_beat("t2.stall", 2, 0, 200, 20, 2);
      end
      i_ready = 1'b1;
      step();
      check_beat("t2.sell", 2, 1, 201, 21, 3);
      step();
      check_idle("t2.end", 4'b0000);

      // 3: coalescing behind a stalled beat for another stock
      i_ready = 1'b0;
      send_quote(0, 50, 0, 5, 0);
      check_idle("t3.n1", 4'b0001);
      step();
      check_beat("t3.s0", 0, 0, 50, 5, 4);
      send_quote(2, 10, 0, 1, 0);
      check("t3.coal0", {16'd0, o_coalesce_cnt}, 32'd0);
      send_quote(2, 11, 0, 1, 0);
      check("t3.coal1", {16'd0, o_coalesce_cnt}, 32'd1);
      send_quote(2, 12, 0, 1, 0);
      check("t3.coal2", {16'd0, o_coalesce_cnt}, 32'd2);
      check("t3.pending", {28'd0, o_pending}, 32'h4);
      check_beat("t3.s0hold", 0, 0, 50, 5, 4);
      i_ready = 1'b1;
      step();
      check("t3.bubble", {31'd0, o_valid}, 32'd0);
      step();
      check_beat("t3.s2", 2, 0, 12, 1, 5);
      check("t3.s2.pending", {28'd0, o_pending}, 32'd0);
      step();
      check_idle("t3.end", 4'b0000);

      // 4: burst to all stocks, then stock 0 again
      i_quote_valid = 1'b1; i_buy_qty = 16'd1; i_sell_qty = 16'd0;
      i_stock_id = 2'd0; i_buy_price = 32'd300;
      step();
      check("t4.a1.pending", {28'd0, o_pending}, 32'h1);
      i_stock_id = 2'd1; i_buy_price = 32'd301;
      step();
      check_beat("t4.b0", 0, 0, 300, 1, 6);
      check("t4.a2.pending", {28'd0, o_pending}, 32'h2);
      i_stock_id = 2'd2; i_buy_price = 32'd302;
      step();
      check_idle("t4.a3", 4'b0110);
      i_stock_id = 2'd3; i_buy_price = 32'd303;
      step();
      check_beat("t4.b1", 1, 0, 301, 1, 7);
      check("t4.a4.pending", {28'd0, o_pending}, 32'hC);
      i_stock_id = 2'd0; i_buy_price = 32'd310;
      step();
      i_quote_valid = 1'b0;
      check_idle("t4.a5", 4'b1101);
      step();
      check_beat("t4.b2", 2, 0, 302, 1, 8);
      step();
      check_idle("t4.a7", 4'b1001);
      step();
      check_beat("t4.b3", 3, 0, 303, 1, 9);
      step();
      check_idle("t4.a9", 4'b0001);
      step();
      check_beat("t4.b0again", 0, 0, 310, 1, 10);
      step();
      check_idle("t4.end", 4'b0000);
      check("t4.coal", {16'd0, o_coalesce_cnt}, 32'd2);

      // Same-slot write during latch: old data goes out, new data stays pending, no coalesce
      send_quote(1, 400, 0, 1, 0);
      check("race.n1.pending", {28'd0, o_pending}, 32'h2);
      send_quote(1, 401, 0, 1, 0);
      check_beat("race.old", 1, 0, 400, 1, 11);
      check("race.pending", {28'd0, o_pending}, 32'h2);
      check("race.coal", {16'd0, o_coalesce_cnt}, 32'd2);
      step();
      check_idle("race.bubble", 4'b0010);
      step();
      check_beat("race.new", 1, 0, 401, 1, 12);
      step();
      check_idle("race.end", 4'b0000);

      // 5: sell-only quote, then an empty quote that must be dropped
      send_quote(3, 55, 66, 0, 7);
      check_idle("t5.n1", 4'b1000);
      step();
      check_beat("t5.sell", 3, 1, 66, 7, 13);
      step();
      check_idle("t5.end", 4'b0000);
      send_quote(2, 1, 2, 0, 0);
      check_idle("t5.zero1", 4'b0000);
      step();
      check_idle("t5.zero2", 4'b0000);

      // 6: reset during SELL with two slots pending
      i_ready = 1'b0;
      send_quote(0, 80, 81, 1, 2);
      step();
      check_beat("t6.buy", 0, 0, 80, 1, 14);
      send_quote(1, 90, 91, 1, 1);
      send_quote(2, 92, 93, 1, 1);
      check("t6.pending", {28'd0, o_pending}, 32'h6);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      check_beat("t6.sell", 0, 1, 81, 2, 15);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      check_idle("t6.rst", 4'b0000);
      check("t6.rst.reg1", o_reg_1, 32'd0);
      check("t6.rst.reg2", o_reg_2, 32'd0);
      check("t6.rst.reg3", o_reg_3, 32'd0);
      check("t6.rst.seq", o_reg_4, 32'd0);
      check("t6.rst.coal", {16'd0, o_coalesce_cnt}, 32'd0);
      step();
      check_idle("t6.after", 4'b0000);
      i_ready = 1'b1;
      send_quote(0, 70, 0, 3, 0);
      step();
      check_beat("t6.restart", 0, 0, 70, 3, 0);
      step();
      check_idle("t6.end", 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
